binoc_channel_alloc: RTL and testbench

Channel allocator for the BiNoC router. It is the responder side of the routing-computation handshake: it collects the 10-bit `channel_req` vectors from every input port's RC stage and resolves contention for the ten output channels. Each output direction is a pair of bidirectional channels: (0,1), (2,3), (4,5), (6,7) and (8,9). For each request it returns a one-hot `channel_gnt` pulse naming the single channel granted, tracks channel ownership until release, and drives owner selects to the crossbar.

---
 rtl/binoc_channel_alloc.sv | 145 ++++++++++++++
 tb/tb_binoc_channel_alloc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binoc_channel_alloc.sv
// ---------------------------------------------------------------------------
// binoc_channel_alloc
//
// Channel allocator for the BiNoC router. It collects per-input channel
// request vectors from the routing-computation stages and hands out the ten
// bidirectional output channels (pairs 2k / 2k+1 form one direction).
// Each channel is FREE or BUSY(owner) and keeps its own round-robin pointer.
//
// Handshake: an input holds channel_req level-high until it sees a one-cycle
// channel_gnt pulse (one-hot, registered); it drops the request one edge
// later, so an input whose grant was high in the previous cycle is masked.
// Ownership lasts until a one-cycle ch_release pulse on that channel.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   channel_req  NUM_IN*NUM_CH  request vectors, input i at [i*NUM_CH +: NUM_CH]
//   ch_avail     NUM_CH         channel configured outbound (grantable)
//   ch_release   NUM_CH         tail flit left the channel; frees a BUSY channel
//   channel_gnt  NUM_IN*NUM_CH  registered grant per input, one-hot or zero
//   ch_busy      NUM_CH         channel owned (also the per-channel state)
//   ch_owner     NUM_CH*OW      owning input per channel, valid while ch_busy
// ---------------------------------------------------------------------------
module binoc_channel_alloc #(
    parameter int NUM_IN = 5,
    parameter int NUM_CH = 10,
    parameter int OW     = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*NUM_CH-1:0] channel_req,
    input  logic [NUM_CH-1:0]        ch_avail,
    input  logic [NUM_CH-1:0]        ch_release,
    output logic [NUM_IN*NUM_CH-1:0] channel_gnt,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH*OW-1:0]     ch_owner
);

    // Registered state
    logic [NUM_CH-1:0]        busy_q;
    logic [OW-1:0]            owner_q [NUM_CH];
    logic [OW-1:0]            rr_q    [NUM_CH];
    logic [NUM_IN*NUM_CH-1:0] gnt_q;

    // Next-state values
    logic [NUM_CH-1:0]        busy_d;
    logic [OW-1:0]            owner_d [NUM_CH];
    logic [OW-1:0]            rr_d    [NUM_CH];
    logic [NUM_IN*NUM_CH-1:0] gnt_d;

    // Per-input helpers
    logic [NUM_CH-1:0] req_a [NUM_IN];
    logic [NUM_CH-1:0] gnt_a [NUM_IN];
    logic [NUM_IN-1:0] owns;
    logic [NUM_IN-1:0] prev;
    logic [NUM_IN-1:0] taken;

    // Eligibility masks: an input that owns a channel, or whose grant is
    // still on the wire this cycle, cannot win anything.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            req_a[i] = channel_req[i*NUM_CH +: NUM_CH];
            prev[i]  = |gnt_q[i*NUM_CH +: NUM_CH];
            owns[i]  = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (busy_q[c] && (owner_q[c] == OW'(i))) begin
                    owns[i] = 1'b1;
                end
            end
        end
    end

    // Allocation. Channels are walked in ascending order and a winner is
    // removed from the pool (taken) so each input gets at most one channel
    // per cycle. Release only acts on channels that are BUSY now, and a
    // freed channel is not grantable until the following edge because the
    // grant test uses the current busy_q.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        taken   = '0;
        busy_d  = busy_q & ~ch_release;
        gnt_d   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            gnt_a[i] = '0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            owner_d[c] = owner_q[c];
            rr_d[c]    = rr_q[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!busy_q[c] && ch_avail[c]) begin
                found = 1'b0;
                for (int k = 0; k < NUM_IN; k++) begin
                    // Round-robin scan starting at the channel's pointer.
                    idx = int'(rr_q[c]) + k;
                    if (idx >= NUM_IN) begin
                        idx = idx - NUM_IN;
                    end
                    if (!found && req_a[idx][c] && !owns[idx] && !prev[idx] && !taken[idx]) begin
                        found        = 1'b1;
                        taken[idx]   = 1'b1;
                        gnt_a[idx][c] = 1'b1;
                        busy_d[c]    = 1'b1;
                        owner_d[c]   = OW'(idx);
                        rr_d[c]      = (idx == NUM_IN - 1) ? '0 : OW'(idx + 1);
                    end
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            gnt_d[i*NUM_CH +: NUM_CH] = gnt_a[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            gnt_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                owner_q[c] <= '0;
                rr_q[c]    <= '0;
            end
        end else begin
            busy_q <= busy_d;
            gnt_q  <= gnt_d;
            for (int c = 0; c < NUM_CH; c++) begin
                owner_q[c] <= owner_d[c];
                rr_q[c]    <= rr_d[c];
            end
        end
    end

    assign channel_gnt = gnt_q;
    assign ch_busy     = busy_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_owner[c*OW +: OW] = owner_q[c];
        end
    end

endmodule

// File: tb/tb_binoc_channel_alloc.sv
// ---------------------------------------------------------------------------
// tb_binoc_channel_alloc
//
// Bench for binoc_channel_alloc. A behavioural model (FREE/BUSY arrays,
// owner and pointer integers) advances on every rising edge from the same
// inputs; a compare process checks grant, busy and owner outputs on every
// falling edge. Directed scenarios with literal expectations come first,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_binoc_channel_alloc;

    localparam int NI = 5;
    localparam int NC = 10;
    localparam int OW = 3;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI*NC-1:0] channel_req;
    logic [NC-1:0]    ch_avail;
    logic [NC-1:0]    ch_release;
    logic [NI*NC-1:0] channel_gnt;
    logic [NC-1:0]    ch_busy;
    logic [NC*OW-1:0] ch_owner;

    binoc_channel_alloc #(.NUM_IN(NI), .NUM_CH(NC), .OW(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .channel_req (channel_req),
        .ch_avail    (ch_avail),
        .ch_release  (ch_release),
        .channel_gnt (channel_gnt),
        .ch_busy     (ch_busy),
        .ch_owner    (ch_owner)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    bit m_busy  [NC];
    int m_owner [NC];
    int m_rr    [NC];
    int m_gnt   [NI];   // granted channel this cycle, -1 if none
    bit m_owns  [NI];
    bit m_prev  [NI];
    bit m_taken [NI];
    int m_new   [NI];
    bit m_pre   [NC];

    always @(posedge clk) begin : model
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_busy[c] = 1'b0; m_owner[c] = 0; m_rr[c] = 0;
            end
            for (int i = 0; i < NI; i++) m_gnt[i] = -1;
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_owns[i] = 1'b0; m_prev[i] = (m_gnt[i] >= 0);
                m_taken[i] = 1'b0; m_new[i] = -1;
            end
            for (int c = 0; c < NC; c++) begin
                m_pre[c] = m_busy[c];
                if (m_busy[c]) m_owns[m_owner[c]] = 1'b1;
            end
            for (int c = 0; c < NC; c++) begin
                if (!m_pre[c] && ch_avail[c]) begin
                    bit done;
                    done = 1'b0;
                    for (int k = 0; k < NI; k++) begin
                        int i;
                        i = (m_rr[c] + k) % NI;
                        if (!done && channel_req[i*NC + c] && !m_owns[i] && !m_prev[i] && !m_taken[i]) begin
                            done = 1'b1;
                            m_taken[i] = 1'b1;
                            m_new[i]   = c;
                            m_busy[c]  = 1'b1;
                            m_owner[c] = i;
                            m_rr[c]    = (i + 1) % NI;
                        end
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (m_pre[c] && ch_release[c]) m_busy[c] = 1'b0;
            end
            for (int i = 0; i < NI; i++) m_gnt[i] = m_new[i];
        end
    end

    // Scoreboard compare, every falling edge once enabled
    logic [NI*NC-1:0] exp_gnt;
    logic [NC-1:0]    exp_busy;
    logic [NC*OW-1:0] exp_owner;
    logic [NC*OW-1:0] owner_mask;

    always @(negedge clk) begin : compare
        if (check_en) begin
            exp_gnt = '0; exp_busy = '0; exp_owner = '0; owner_mask = '0;
            for (int i = 0; i < NI; i++)
                if (m_gnt[i] >= 0) exp_gnt[i*NC + m_gnt[i]] = 1'b1;
            for (int c = 0; c < NC; c++) begin
                if (m_busy[c]) begin
                    exp_busy[c] = 1'b1;
                    exp_owner[c*OW +: OW] = OW'(m_owner[c]);
                    owner_mask[c*OW +: OW] = '1;
                end
            end
            tests++;
            if (channel_gnt !== exp_gnt) begin
                fails++;
                $display("FAIL model_gnt t=%0t got=%h exp=%h", $time, channel_gnt, exp_gnt);
            end
            tests++;
            if (ch_busy !== exp_busy) begin
                fails++;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, ch_busy, exp_busy);
            end
            tests++;
            if ((ch_owner & owner_mask) !== exp_owner) begin
                fails++;
                $display("FAIL model_owner t=%0t got=%h exp=%h", $time, ch_owner & owner_mask, exp_owner);
            end
        end
    end

    // Driver / check helpers
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] gsl(input int i);
        return channel_gnt[i*NC +: NC];
    endfunction

    function automatic logic [OW-1:0] own(input int c);
        return ch_owner[c*OW +: OW];
    endfunction

    task automatic set_req(input int i, input logic [NC-1:0] v);
        channel_req[i*NC +: NC] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; channel_req = '0; ch_release = '0;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    logic [NC-1:0] hold [NI];

    initial begin : main
        int got;
        rst = 1'b1;
        channel_req = '1;
        ch_avail = '1;
        ch_release = '0;

        // Reset with requests active
        cyc(1);
        check_en = 1'b1;
        check("rst_gnt0", channel_gnt, '0);
        check("rst_busy0", ch_busy, '0);
        cyc(1);
        check("rst_gnt1", channel_gnt, '0);
        check("rst_busy1", ch_busy, '0);
        check("rst_owner", ch_owner, '0);
        channel_req = '0;
        rst = 1'b0;
        cyc(1);
        check("post_rst_gnt", channel_gnt, '0);
        check("post_rst_busy", ch_busy, '0);

        // Single request
        set_req(0, 10'b00_0000_0011);
        cyc(1);
        check("single_gnt", gsl(0), 10'b00_0000_0001);
        check("single_busy", ch_busy, 10'b00_0000_0001);
        check("single_owner", own(0), 3'd0);
        cyc(1);
        check("single_no_regrant", channel_gnt, '0);
        check("single_busy_hold", ch_busy, 10'b00_0000_0001);
        set_req(0, '0);
        cyc(1);
        // Reset while ch0 is BUSY
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_free", ch_busy, '0);

        // Pair split
        set_req(0, 10'b00_0000_0011);
        set_req(2, 10'b00_0000_0011);
        cyc(1);
        check("split_gnt0", gsl(0), 10'b00_0000_0001);
        check("split_gnt2", gsl(2), 10'b00_0000_0010);
        check("split_own0", own(0), 3'd0);
        check("split_own1", own(1), 3'd2);
        set_req(0, '0); set_req(2, '0);
        cyc(1);

        // Contention and release
        do_reset();
        set_req(0, 10'b00_0000_0011);
        set_req(2, 10'b00_0000_0011);
        set_req(4, 10'b00_0000_0011);
        cyc(1);
        check("cont_gnt0", gsl(0), 10'b00_0000_0001);
        check("cont_gnt2", gsl(2), 10'b00_0000_0010);
        check("cont_gnt4", gsl(4), '0);
        set_req(0, '0); set_req(2, '0);
        for (int t = 0; t < 4; t++) begin
            cyc(1);
            check("cont_wait4", gsl(4), '0);
        end
        ch_release = 10'b00_0000_0010;
        cyc(1);
        ch_release = '0;
        check("cont_rel_edge_gnt4", gsl(4), '0);
        check("cont_rel_freed", ch_busy, 10'b00_0000_0001);
        cyc(1);
        check("cont_regrant4", gsl(4), 10'b00_0000_0010);
        check("cont_own1", own(1), 3'd4);
        set_req(4, '0);
        cyc(1);

        // Round-robin fairness on a single channel
        do_reset();
        ch_avail = 10'b00_0000_0001;
        set_req(1, 10'b00_0000_0001);
        set_req(3, 10'b00_0000_0001);
        for (int n = 0; n < 8; n++) begin
            got = -1;
            for (int t = 0; t < 20 && got < 0; t++) begin
                cyc(1);
                if (gsl(1) != '0) got = 1;
                else if (gsl(3) != '0) got = 3;
            end
            check("rr_winner", 64'(got), (n % 2 == 0) ? 64'd1 : 64'd3);
            cyc(2);
            ch_release = 10'b00_0000_0001;
            cyc(1);
            ch_release = '0;
        end
        set_req(1, '0); set_req(3, '0);
        cyc(1);

        // Availability gating
        do_reset();
        ch_avail = ~10'b00_0011_0000;
        set_req(3, 10'b00_0011_0000);
        for (int t = 0; t < 3; t++) begin
            cyc(1);
            check("gate_nogrant", channel_gnt, '0);
        end
        ch_avail[5] = 1'b1;
        cyc(1);
        check("gate_grant", gsl(3), 10'b00_0010_0000);
        check("gate_busy", ch_busy, 10'b00_0010_0000);
        ch_avail[5] = 1'b0;
        set_req(3, '0);
        for (int t = 0; t < 3; t++) begin
            cyc(1);
            check("gate_keep_busy", 64'(ch_busy[5]), 64'd1);
        end
        ch_release = 10'b00_0010_0000;
        cyc(1);
        ch_release = '0;
        check("gate_released", 64'(ch_busy[5]), 64'd0);

        // Randomized phase: RC-like requesters hold a pair request until
        // granted, occasionally keeping it one cycle too long.
        do_reset();
        for (int i = 0; i < NI; i++) hold[i] = '0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NI; i++) begin
                if (gsl(i) != '0) begin
                    if ($urandom_range(0, 3) != 0) hold[i] = '0;
                end else if (hold[i] == '0 && $urandom_range(0, 2) == 0) begin
                    int d;
                    d = $urandom_range(0, 4);
                    case ($urandom_range(0, 3))
                        0: hold[i][2*d] = 1'b1;
                        1: hold[i][2*d+1] = 1'b1;
                        default: begin hold[i][2*d] = 1'b1; hold[i][2*d+1] = 1'b1; end
                    endcase
                end
                set_req(i, hold[i]);
            end
            for (int c = 0; c < NC; c++) begin
                ch_avail[c]   = ($urandom_range(0, 7) != 0);
                ch_release[c] = m_busy[c] ? ($urandom_range(0, 5) == 0)
                                          : ($urandom_range(0, 29) == 0);
            end
            cyc(1);
        end
        rst = 1'b0;
        channel_req = '0;
        ch_release = '0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
